// File: rtl/subtrator_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding, default width,
// and the counter-width helper used by the controller.
package subtrator_pkg;

    localparam int SUB_N_DEF = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // A one-bit counter is still needed when N=1 ($clog2(1) is 0).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtrator_completo.sv
// Single-bit full subtractor: D = A - B - Bin, Borrow is the borrow-out.
module subtrator_completo (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Borrow
);

    assign D      = A ^ B ^ Bin;
    assign Borrow = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial N-bit subtractor controller: feeds one full-subtractor cell LSB first,
// one bit per clock, with a start/busy/done handshake and registered D/Borrow.
module subtrator_serial_ctrl
    import subtrator_pkg::*;
#(
    parameter int N = SUB_N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         Borrow
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state_q,  state_d;
    logic [N-1:0]  a_q,      a_d;
    logic [N-1:0]  b_q,      b_d;
    logic [N-1:0]  res_q,    res_d;
    logic [N-1:0]  d_q,      d_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          bin_q,    bin_d;
    logic          borrow_q, borrow_d;

    logic bit_d;
    logic bit_bout;

    subtrator_completo u_cell (
        .A      (a_q[0]),
        .B      (b_q[0]),
        .Bin    (bin_q),
        .D      (bit_d),
        .Borrow (bit_bout)
    );

    always_comb begin
        // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                res_d        = res_q >> 1;
                res_d[N-1]   = bit_d;
                bin_d        = bit_bout;
                cnt_d        = cnt_q + CW'(1);
                // The last bit lands in res_d this cycle, so publish res_d, not res_q.
                if (cnt_q == LAST) begin
                    d_d      = res_d;
                    borrow_d = bit_bout;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign D      = d_q;
    assign Borrow = borrow_q;

endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
// Self-checking bench for subtrator_serial_ctrl at N=8 (main), N=1 and N=16.
module tb_subtrator_serial_ctrl;

    localparam int N8 = 8;

    logic clk = 1'b0;
    logic rst;

    logic       start;
    logic [7:0] a, b, d;
    logic       busy, done, borrow;

    logic       start1, a1, b1, d1, busy1, done1, borrow1;

    logic        start16;
    logic [15:0] a16, b16, d16;
    logic        busy16, done16, borrow16;

    subtrator_serial_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
        .busy(busy), .done(done), .D(d), .Borrow(borrow)
    );

    subtrator_serial_ctrl #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .D(d1), .Borrow(borrow1)
    );

    subtrator_serial_ctrl #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .D(d16), .Borrow(borrow16)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       br;
    } exp8_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    exp8_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] t;
        t = {1'b0, x} - {1'b0, y};
        return {t[7:0], t[8]};
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("busy_done_excl8",  {31'b0, busy & done}, 32'd0);
            check("busy_done_excl1",  {31'b0, busy1 & done1}, 32'd0);
            check("busy_done_excl16", {31'b0, busy16 & done16}, 32'd0);
        end
    end

    // Counts negedges until done; on done pops the scoreboard and compares.
    task automatic wait_done8(input string tag, output int lat, output int bcnt);
        exp8_t e;
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 60);
        if (!done) begin
            check({tag, "_timeout"}, {31'b0, done}, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            check({tag, "_unexpected_done"}, {31'b0, done}, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_D"}, {24'b0, d}, {24'b0, e.d});
            check({tag, "_Borrow"}, {31'b0, borrow}, {31'b0, e.br});
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] ed, input logic ebr);
        int lat, bcnt;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        sb.push_back({ed, ebr});
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_first"}, {31'b0, busy}, 32'd1);
        wait_done8(tag, lat, bcnt);
        check({tag, "_latency"}, lat + 1, N8 + 1);
        check({tag, "_busy_cycles"}, bcnt + 1, N8);
    endtask

    initial begin
        vec_t vecs[5];
        int   lat, bcnt, n, ndone;
        exp8_t e;
        logic [7:0] rx, ry;

        vecs[0] = '{a: 8'd100,  b: 8'd37,   d: 8'd63,   br: 1'b0};
        vecs[1] = '{a: 8'd5,    b: 8'd9,    d: 8'hFC,   br: 1'b1};
        vecs[2] = '{a: 8'h00,   b: 8'h01,   d: 8'hFF,   br: 1'b1};
        vecs[3] = '{a: 8'hFF,   b: 8'hFF,   d: 8'h00,   br: 1'b0};
        vecs[4] = '{a: 8'd200,  b: 8'd1,    d: 8'd199,  br: 1'b0};

        rst = 1'b1;
        start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   {31'b0, busy},   32'd0);
        check("reset_done",   {31'b0, done},   32'd0);
        check("reset_D",      {24'b0, d},      32'd0);
        check("reset_Borrow", {31'b0, borrow}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br);

        for (int i = 0; i < 4; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            e  = model8(rx, ry);
            op8($sformatf("rand%0d", i), rx, ry, e.d, e.br);
        end

        // Back-to-back: start held high, operands changed right after acceptance.
        @(negedge clk);
        a = 8'd50; b = 8'd60; start = 1'b1;
        sb.push_back(model8(8'd50, 8'd60));
        @(negedge clk);
        a = 8'd77; b = 8'd7;
        sb.push_back(model8(8'd77, 8'd7));
        wait_done8("b2b_first", lat, bcnt);
        check("b2b_first_latency", lat, N8);
        wait_done8("b2b_second", lat, bcnt);
        check("b2b_spacing", lat, N8 + 2);
        start = 1'b0;

        // Reset on the 4th SHIFT cycle abandons the operation.
        @(negedge clk);
        a = 8'd200; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   {31'b0, busy},   32'd0);
        check("abort_done",   {31'b0, done},   32'd0);
        check("abort_D",      {24'b0, d},      32'd0);
        check("abort_Borrow", {31'b0, borrow}, 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        op8("after_abort", 8'd3, 8'd3, 8'd0, 1'b0);

        // Bus changes during SHIFT must not disturb the captured operands.
        @(negedge clk);
        a = 8'd10; b = 8'd4; start = 1'b1;
        sb.push_back({8'd6, 1'b0});
        @(negedge clk);
        start = 1'b0; a = 8'd0; b = 8'd255;
        wait_done8("bus_change", lat, bcnt);
        @(negedge clk);
        check("hold_idle_D", {24'b0, d}, 32'd6);
        a = 8'd50; b = 8'd20; start = 1'b1;
        sb.push_back({8'd30, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_shift_D", {24'b0, d}, 32'd6);
        wait_done8("after_hold", lat, bcnt);

        // N=1: one SHIFT cycle, done two cycles after the start edge.
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("n1_busy", {31'b0, busy1}, 32'd1);
        @(negedge clk);
        check("n1_done",   {31'b0, done1},   32'd1);
        check("n1_D",      {31'b0, d1},      32'd1);
        check("n1_Borrow", {31'b0, borrow1}, 32'd1);

        // N=16: done 17 cycles after the start edge.
        @(negedge clk);
        a16 = 16'h1000; b16 = 16'h0001; start16 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start16 = 1'b0;
            n++;
        end while (!done16 && n < 60);
        check("n16_latency", n, 17);
        check("n16_D",      {16'b0, d16},      32'h0FFF);
        check("n16_Borrow", {31'b0, borrow16}, 32'd0);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/subtrator_serial_ctrl.md
Name: subtrator_serial_ctrl

Overview:
Bit-serial N-bit subtractor controller. It sequences one full-subtractor cell over the operand bits, LSB first, one bit per clock, and carries the borrow between cycles. Uses a start/busy/done handshake and returns the difference D = A - B (mod 2^N) plus the final borrow. It sits between a register-level requester and the single-bit subtractor datapath, so one cell serves any operand width.

Parameters:
N, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
A  input  N  minuend; captured on the accepted start edge.
B  input  N  subtrahend; captured on the accepted start edge.
busy  output  1  high while an operation is in SHIFT.
done  output  1  single-cycle pulse; D/Borrow valid.
D  output  N  difference A - B modulo 2^N; registered.
Borrow  output  1  final borrow; 1 iff A < B (unsigned); registered.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, D=0, Borrow=0, counter=0, internal borrow=0. rst has priority over every other input, including mid-SHIFT: the operation is abandoned and no done is produced.
- States: IDLE, SHIFT, DONE; encoding is in the package.
- IDLE: on an edge with start=1, load shift_a<=A, shift_b<=B, bin<=0, cnt<=0, go to SHIFT. busy=1 from the next cycle. With start=0, stay in IDLE.
- SHIFT: each edge processes bit i=cnt:
  - d_i = a^b^bin.
  - bout = (~a & b) | (~(a^b) & bin).
  - d_i shifts into the MSB of the result shift register; shift_a and shift_b shift right; bin<=bout; cnt<=cnt+1.
  - On the edge where cnt==N-1: D<=final result register, Borrow<=bout, go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally return to IDLE.
- Latency: start accepted at edge k; busy high during cycles k+1..k+N; done high during cycle k+N+1. Minimum start-to-start spacing is N+2 cycles.
- start is ignored in SHIFT and DONE; no queuing. A/B changes after the accepted edge have no effect.
- D and Borrow change only on the DONE transition (or reset). They hold their values through IDLE and the next SHIFT until that operation's DONE.
- busy and done are never high simultaneously.
- Counter width is max(1, $clog2(N)). N=1 takes exactly one SHIFT cycle.
- Arithmetic is unsigned modulo 2^N; Borrow is the true borrow-out of the MSB.

Decomposition:
- Package subtrator_pkg holds:
  - the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default width constant SUB_N_DEF=8.
- One combinational sub-module, subtrator_completo (ports A, B, Bin, D, Borrow), is instantiated once for the per-bit difference/borrow. The controller holds all registers.

Test Plan:
- N=8, reset, then start with A=100, B=37 -> busy high for 8 cycles, done pulse at cycle 9 after start; D=63, Borrow=0.
- A=5, B=9 -> D=8'hFC, Borrow=1. Then A=8'h00, B=8'h01 -> D=8'hFF, Borrow=1 (borrow chain through all bits).
- A=B=8'hFF -> D=0, Borrow=0. Back-to-back: assert start continuously; operations accepted every 10 cycles; start pulses during busy/done are ignored and the operands are not recaptured.
- Assert rst at the 4th SHIFT cycle of A=200, B=1 -> next cycle busy=0, done=0, D=0, Borrow=0; no done pulse. A following start (A=3, B=3) completes normally with D=0, Borrow=0.
- Change A/B during SHIFT (captured A=10, B=4; bus then shows A=0, B=255) -> result D=6, Borrow=0. D holds 6 through IDLE and the next SHIFT until the next done.
- Parameter sweep N=1 (A=0, B=1 -> D=1, Borrow=1, done 2 cycles after start) and N=16 (A=16'h1000, B=16'h0001 -> D=16'h0FFF, Borrow=0, done 17 cycles after start).
